// File: rtl/dftprobe_sequencer.sv
// dftprobe_sequencer: walks a latched probe mask, enabling one probe cell at a time
// and capturing each probe's synchronized observe output after a settle period.
module dftprobe_sequencer #(
    parameter int N_PROBE = 8,
    parameter int SETTLE  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic [N_PROBE-1:0] probe_mask,
    input  logic [N_PROBE-1:0] tdi,
    output logic [N_PROBE-1:0] ten,
    output logic [N_PROBE-1:0] result,
    output logic               busy,
    output logic               done,
    output logic               aborted
);
    localparam int IW = $clog2(N_PROBE);
    localparam int CW = $clog2(SETTLE);
    localparam logic [IW-1:0] LAST = IW'(N_PROBE - 1);
    localparam logic [N_PROBE-1:0] ONE = 1;

    typedef enum logic [2:0] {S_IDLE, S_SCAN, S_SETTLE, S_CAPTURE, S_GAP, S_DONE} state_t;

    state_t state, nxt;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
    logic [N_PROBE-1:0] mask, tdi_m, tdi_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:    nxt = start ? S_SCAN : S_IDLE;
            S_SCAN:    nxt = mask[idx] ? S_SETTLE : (idx == LAST ? S_DONE : S_SCAN);
            S_SETTLE:  nxt = (cnt == '0) ? S_CAPTURE : S_SETTLE;
            S_CAPTURE: nxt = S_GAP;
            S_GAP:     nxt = (idx == LAST) ? S_DONE : S_SCAN;
            default:   nxt = S_IDLE;
        endcase
        if (state != S_IDLE && abort) nxt = S_IDLE;
    end

    always_comb begin
        done = (state == S_DONE);
        busy = (state != S_IDLE) || aborted;
    end

    // Datapath updates key off nxt so an abort suppresses any pending capture or step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdi_m   <= '0;
            tdi_s   <= '0;
            ten     <= '0;
            result  <= '0;
            mask    <= '0;
            idx     <= '0;
            cnt     <= '0;
            aborted <= 1'b0;
        end else begin
            tdi_m   <= tdi;
            tdi_s   <= tdi_m;
            aborted <= (state != S_IDLE) && abort;
            ten     <= (nxt == S_SETTLE || nxt == S_CAPTURE) ? ONE << idx : '0;
            if (state == S_IDLE && start) begin
                mask   <= probe_mask;
                result <= '0;
                idx    <= '0;
            end
            if ((state == S_SCAN || state == S_GAP) && nxt == S_SCAN) idx <= idx + 1'b1;
            if (nxt == S_SETTLE) cnt <= (state == S_SCAN) ? CW'(SETTLE - 1) : cnt - 1'b1;
            if (state == S_CAPTURE && nxt == S_GAP) result[idx] <= tdi_s[idx];
        end
    end
endmodule

// File: tb/tb_dftprobe_sequencer.sv
// tb_dftprobe_sequencer: directed checks of scan timing, capture, abort and reset
// for dftprobe_sequencer with default parameters.
module tb_dftprobe_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] probe_mask = 8'h00;
    logic [7:0] tdi = 8'h00;
    logic [7:0] ten, result;
    logic       busy, done, aborted;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int bad_oh = 0;
    int hi[8];
    int done_cnt;

    dftprobe_sequencer #(.N_PROBE(8), .SETTLE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .probe_mask(probe_mask), .tdi(tdi), .ten(ten), .result(result),
        .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Start is sampled on the next edge; afterwards cyc counts cycles since that edge.
    task automatic launch(input logic [7:0] m);
        probe_mask = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        bad_oh = 0;
        for (int i = 0; i < 8; i++) hi[i] = 0;
    endtask

    task automatic wait_done(input int limit);
        while (done !== 1'b1 && cyc < limit) begin
            if (!$onehot0(ten)) bad_oh++;
            for (int i = 0; i < 8; i++) hi[i] += int'(ten[i]);
            tick();
        end
    endtask

    function automatic logic [7:0] hi_mask();
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) m[i] = (hi[i] != 0);
        return m;
    endfunction

    task automatic settle_tdi(input logic [7:0] v);
        tdi = v;
        repeat (3) tick();
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        chk("rst_ten", 32'(ten), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_aborted", 32'(aborted), 0);

        settle_tdi(8'hA5);
        launch(8'hFF);
        wait_done(200);
        chk("full_done_cyc", 32'(cyc), 57);
        chk("full_result", 32'(result), 32'hA5);
        chk("full_onehot", 32'(bad_oh), 0);
        for (int i = 0; i < 8; i++) chk($sformatf("full_hi%0d", i), 32'(hi[i]), 5);
        chk("full_busy_in_done", 32'(busy), 1);
        tick();
        chk("full_done_pulse", 32'(done), 0);
        chk("full_busy_after", 32'(busy), 0);
        chk("full_result_hold", 32'(result), 32'hA5);

        launch(8'h00);
        wait_done(200);
        chk("empty_done_cyc", 32'(cyc), 9);
        chk("empty_result", 32'(result), 0);
        chk("empty_ten", 32'(hi_mask()), 0);
        tick();

        settle_tdi(8'hFF);
        launch(8'h81);
        wait_done(200);
        chk("sparse_done_cyc", 32'(cyc), 21);
        chk("sparse_result", 32'(result), 32'h81);
        chk("sparse_ten_bits", 32'(hi_mask()), 32'h81);
        chk("sparse_hi0", 32'(hi[0]), 5);
        chk("sparse_hi7", 32'(hi[7]), 5);
        chk("sparse_onehot", 32'(bad_oh), 0);
        tick();

        settle_tdi(8'hA5);
        launch(8'hFF);
        repeat (23) tick();
        chk("abort_ten_before", 32'(ten), 32'h08);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ten", 32'(ten), 0);
        chk("abort_pulse", 32'(aborted), 1);
        chk("abort_no_done", 32'(done), 0);
        tick();
        chk("abort_pulse_end", 32'(aborted), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_result", 32'(result), 32'h05);
        done_cnt = 0;
        repeat (70) begin
            done_cnt += int'(done);
            tick();
        end
        chk("abort_never_done", 32'(done_cnt), 0);

        settle_tdi(8'h00);
        launch(8'hFF);
        repeat (11) tick();
        tdi = 8'h02;
        wait_done(200);
        chk("sync_late", 32'(result), 0);
        tick();
        settle_tdi(8'h00);
        launch(8'hFF);
        repeat (9) tick();
        tdi = 8'h02;
        wait_done(200);
        chk("sync_early", 32'(result), 32'h02);
        tick();

        settle_tdi(8'hFF);
        launch(8'h81);
        repeat (2) tick();
        start = 1'b1;
        probe_mask = 8'h00;
        repeat (8) tick();
        start = 1'b0;
        wait_done(200);
        chk("busy_start_cyc", 32'(cyc), 21);
        chk("busy_start_result", 32'(result), 32'h81);
        tick();

        launch(8'hFF);
        repeat (10) tick();
        chk("midrst_ten_before", 32'(ten), 32'h02);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_ten", 32'(ten), 0);
        chk("midrst_result", 32'(result), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_done", 32'(done), 0);
        chk("midrst_aborted", 32'(aborted), 0);
        #2;
        rst = 1'b0;
        tick();
        launch(8'h81);
        wait_done(200);
        chk("post_rst_cyc", 32'(cyc), 21);
        chk("post_rst_result", 32'(result), 32'h81);
        chk("post_rst_ten_bits", 32'(hi_mask()), 32'h81);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
